morty_hazard_ctrl: RTL and testbench

MORTY_HAZARD_CTRL -- requirements
Module: morty_hazard_ctrl

---
 rtl/morty_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_morty_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/morty_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes, MEM-stage
// wait with timeout, and a one-cycle trap redirect. Tracks total PC stall cycles.
module morty_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_reg_we,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        exc_valid,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        stall_exmem,
  output logic        clear_ifid,
  output logic        clear_idex,
  output logic        clear_exmem,
  output logic        clear_memwb,
  output logic [1:0]  pc_sel,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_TRAP     = 2'd2;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_TRAP   = 2'b10;

  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  logic [1:0]  state_reg, state_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic [31:0] stall_cnt_reg;
  logic        load_use;
  logic        mem_stall;

  assign load_use = ex_is_load & ex_reg_we & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign mem_stall = mem_req & ~mem_ack;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    stall_pc      = 1'b0;
    stall_ifid    = 1'b0;
    stall_idex    = 1'b0;
    stall_exmem   = 1'b0;
    clear_ifid    = 1'b0;
    clear_idex    = 1'b0;
    clear_exmem   = 1'b0;
    clear_memwb   = 1'b0;
    pc_sel        = PC_SEQ;
    mem_timeout   = 1'b0;

    case (state_reg)
      ST_RUN: begin
        wait_cnt_next = 8'd0;
        if (exc_valid) begin
          stall_pc    = 1'b1;
          clear_ifid  = 1'b1;
          clear_idex  = 1'b1;
          clear_exmem = 1'b1;
          state_next  = ST_TRAP;
        end else if (mem_stall) begin
          stall_pc      = 1'b1;
          stall_ifid    = 1'b1;
          stall_idex    = 1'b1;
          stall_exmem   = 1'b1;
          clear_memwb   = 1'b1;
          wait_cnt_next = 8'd1;
          state_next    = ST_MEM_WAIT;
        end else if (ex_branch_taken) begin
          pc_sel     = PC_BRANCH;
          clear_ifid = 1'b1;
          clear_idex = 1'b1;
        end else if (load_use) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          clear_idex = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // Only the memory handshake matters here; branches and exceptions wait in EX/MEM.
        if (mem_ack) begin
          wait_cnt_next = 8'd0;
          state_next    = ST_RUN;
        end else if (wait_cnt_reg == TIMEOUT_VAL) begin
          mem_timeout   = 1'b1;
          stall_pc      = 1'b1;
          clear_ifid    = 1'b1;
          clear_idex    = 1'b1;
          clear_exmem   = 1'b1;
          clear_memwb   = 1'b1;
          wait_cnt_next = 8'd0;
          state_next    = ST_TRAP;
        end else begin
          stall_pc      = 1'b1;
          stall_ifid    = 1'b1;
          stall_idex    = 1'b1;
          stall_exmem   = 1'b1;
          clear_memwb   = 1'b1;
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      ST_TRAP: begin
        pc_sel        = PC_TRAP;
        clear_ifid    = 1'b1;
        clear_idex    = 1'b1;
        wait_cnt_next = 8'd0;
        state_next    = ST_RUN;
      end
      default: begin
        wait_cnt_next = 8'd0;
        state_next    = ST_RUN;
      end
    endcase

    // Reset flushes every pipeline register and suppresses all other actions.
    if (rst) begin
      state_next    = ST_RUN;
      wait_cnt_next = 8'd0;
      stall_pc      = 1'b0;
      stall_ifid    = 1'b0;
      stall_idex    = 1'b0;
      stall_exmem   = 1'b0;
      clear_ifid    = 1'b1;
      clear_idex    = 1'b1;
      clear_exmem   = 1'b1;
      clear_memwb   = 1'b1;
      pc_sel        = PC_SEQ;
      mem_timeout   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      wait_cnt_reg  <= 8'd0;
      stall_cnt_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (stall_pc) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_morty_hazard_ctrl.sv
// Directed bench for morty_hazard_ctrl (MEM_TIMEOUT=4): checks the packed
// control-output vector and the stall counter after each hand-built step.
module tb_morty_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_is_load, ex_reg_we, ex_branch_taken;
  logic        mem_req, mem_ack, exc_valid;
  logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic        clear_ifid, clear_idex, clear_exmem, clear_memwb;
  logic [1:0]  pc_sel;
  logic        mem_timeout;
  logic [31:0] stall_cnt;

  int vectors = 0;
  int errors  = 0;

  // {stall_pc,stall_ifid,stall_idex,stall_exmem, clear_ifid,clear_idex,clear_exmem,clear_memwb, pc_sel, mem_timeout}
  localparam logic [10:0] O_RST  = 11'b0000_1111_00_0;
  localparam logic [10:0] O_IDLE = 11'b0000_0000_00_0;
  localparam logic [10:0] O_LU   = 11'b1100_0100_00_0;
  localparam logic [10:0] O_BR   = 11'b0000_1100_01_0;
  localparam logic [10:0] O_EXC  = 11'b1000_1110_00_0;
  localparam logic [10:0] O_MW   = 11'b1111_0001_00_0;
  localparam logic [10:0] O_TO   = 11'b1000_1111_00_1;
  localparam logic [10:0] O_TRAP = 11'b0000_1100_10_0;

  morty_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_reg_we(ex_reg_we),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .exc_valid(exc_valid),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem),
    .clear_ifid(clear_ifid), .clear_idex(clear_idex), .clear_exmem(clear_exmem),
    .clear_memwb(clear_memwb),
    .pc_sel(pc_sel), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_reg_we = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0; exc_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    #1;
    obs = {stall_pc, stall_ifid, stall_idex, stall_exmem,
           clear_ifid, clear_idex, clear_exmem, clear_memwb, pc_sel, mem_timeout};
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: outputs observed %b expected %b", tag, obs, exp);
    end
    $display("vec %0d %s outputs=%b", vectors, tag, obs);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    vectors++;
    assert (stall_cnt === exp) else begin
      errors++;
      $error("FAIL %s: stall_cnt observed %0d expected %0d", tag, stall_cnt, exp);
    end
    $display("vec %0d %s stall_cnt=%0d", vectors, tag, stall_cnt);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    chk_out("reset_outputs", O_RST);
    tick();
    tick();
    chk_cnt("reset_cnt", 32'd0);

    rst = 1'b0;
    chk_out("idle", O_IDLE);
    tick();
    chk_cnt("idle_cnt", 32'd0);

    // Load-use on rs1
    ex_is_load = 1'b1; ex_reg_we = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    chk_out("load_use_rs1", O_LU);
    tick();
    chk_cnt("load_use_cnt", 32'd1);
    idle_inputs();
    chk_out("after_bubble", O_IDLE);

    // Same operands on x0: no hazard
    ex_is_load = 1'b1; ex_reg_we = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    chk_out("load_use_x0", O_IDLE);
    // rs2 match, then variants that must not stall
    idle_inputs();
    ex_is_load = 1'b1; ex_reg_we = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    chk_out("load_use_rs2", O_LU);
    id_use_rs2 = 1'b0;
    chk_out("rs2_not_used", O_IDLE);
    id_use_rs2 = 1'b1; ex_reg_we = 1'b0;
    chk_out("no_reg_we", O_IDLE);
    ex_reg_we = 1'b1; ex_is_load = 1'b0;
    chk_out("not_load", O_IDLE);
    ex_is_load = 1'b1;
    tick();
    chk_cnt("rs2_cnt", 32'd2);

    // Branch together with load-use: flush only
    ex_branch_taken = 1'b1;
    chk_out("branch_over_lu", O_BR);
    tick();
    chk_cnt("branch_cnt", 32'd2);

    // Request acked in the same cycle
    idle_inputs();
    mem_req = 1'b1; mem_ack = 1'b1;
    chk_out("req_ack_same", O_IDLE);
    tick();

    // Ack three cycles after the request; exception/branch ignored while waiting
    mem_ack = 1'b0;
    chk_out("mem_req_run", O_MW);
    tick();
    chk_out("mem_wait_1", O_MW);
    tick();
    exc_valid = 1'b1; ex_branch_taken = 1'b1;
    chk_out("mem_wait_ignores", O_MW);
    tick();
    exc_valid = 1'b0;
    mem_ack = 1'b1;
    chk_out("mem_ack_release", O_IDLE);
    tick();
    chk_cnt("mem_wait_cnt", 32'd5);
    mem_req = 1'b0; mem_ack = 1'b0;
    chk_out("held_branch_taken", O_BR);
    tick();

    // Timeout on the fifth stalled cycle, then one TRAP cycle
    idle_inputs();
    mem_req = 1'b1;
    chk_out("to_stall_1", O_MW);
    tick();
    chk_out("to_stall_2", O_MW);
    tick();
    chk_out("to_stall_3", O_MW);
    tick();
    chk_out("to_stall_4", O_MW);
    tick();
    chk_out("timeout_pulse", O_TO);
    tick();
    exc_valid = 1'b1;
    chk_out("timeout_trap", O_TRAP);
    tick();
    idle_inputs();
    chk_out("timeout_back_run", O_IDLE);
    chk_cnt("timeout_cnt", 32'd10);

    // Exception beats a pending memory stall
    exc_valid = 1'b1; mem_req = 1'b1;
    chk_out("exc_over_mem", O_EXC);
    tick();
    chk_out("exc_trap", O_TRAP);
    tick();
    idle_inputs();
    chk_out("exc_back_run", O_IDLE);
    chk_cnt("exc_cnt", 32'd11);

    // Reset while in MEM_WAIT
    mem_req = 1'b1;
    chk_out("pre_rst_wait", O_MW);
    tick();
    rst = 1'b1;
    chk_out("rst_in_wait", O_RST);
    tick();
    rst = 1'b0;
    idle_inputs();
    chk_out("rst_wait_run", O_IDLE);
    chk_cnt("rst_wait_cnt", 32'd0);

    // Reset while in TRAP
    exc_valid = 1'b1;
    chk_out("pre_rst_trap", O_EXC);
    tick();
    idle_inputs();
    rst = 1'b1;
    chk_out("rst_in_trap", O_RST);
    tick();
    rst = 1'b0;
    chk_out("rst_trap_run", O_IDLE);
    chk_cnt("rst_trap_cnt", 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
